mem_bus_arbiter: RTL and testbench

// - Shares the processor's single-port synchronous memory between two masters: the processor (P) and a DMA/IO master (D).
// - P covers the ldADDR/fetch, ld and st traffic; D covers external load/dump.
// - Sits between the processor datapath/control FSM and the memory.
// - Serialises accesses with round-robin fairness and returns read data to the owning master.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/arb_rr2.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT} arb_state_t;
  typedef enum logic {OWN_P, OWN_D} owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_P) ? OWN_D : OWN_P;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin pick between the processor and the DMA master.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic   i_p_req,
  input  logic   i_d_req,
  input  owner_t i_last_owner,
  output owner_t o_owner,
  output logic   o_any
);

  always_comb begin
    o_any   = i_p_req | i_d_req;
    o_owner = OWN_P;
    // On a tie the master that did not win last time gets the bus.
    if (i_p_req && i_d_req) begin
      o_owner = other_owner(i_last_owner);
    end else if (i_d_req) begin
      o_owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises processor and DMA accesses onto one single-port synchronous memory,
// with round-robin fairness and read data returned to the owning master.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = 9,
  parameter int DW     = 9,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_gnt,
  output logic          p_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] LAT_INIT = CW'(RD_LAT - 1);

  arb_state_t    r_state;
  arb_state_t    w_state_next;
  owner_t        r_owner;
  owner_t        r_last_owner;
  logic          r_we;
  logic [CW-1:0] r_lat_cnt;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  owner_t        w_owner;
  logic          w_any;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_gnt;
  logic          w_rvalid;
  logic          w_mem_we;

  arb_rr2 u_rr (
    .i_p_req      (p_req),
    .i_d_req      (d_req),
    .i_last_owner (r_last_owner),
    .o_owner      (w_owner),
    .o_any        (w_any)
  );

  assign w_sel_we    = (w_owner == OWN_D) ? d_we    : p_we;
  assign w_sel_addr  = (w_owner == OWN_D) ? d_addr  : p_addr;
  assign w_sel_wdata = (w_owner == OWN_D) ? d_wdata : p_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= OWN_P;
      r_last_owner <= OWN_D;
      r_we         <= 1'b0;
      r_lat_cnt    <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner      <= w_owner;
            r_last_owner <= w_owner;
            r_we         <= w_sel_we;
            r_mem_addr   <= w_sel_addr;
            r_mem_wdata  <= w_sel_wdata;
          end
        end
        ACCESS: begin
          if (!r_we) r_lat_cnt <= LAT_INIT;
        end
        RWAIT: begin
          if (r_lat_cnt != '0) r_lat_cnt <= r_lat_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_gnt        = 1'b0;
    w_rvalid     = 1'b0;
    w_mem_we     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_next = ACCESS;
      end
      ACCESS: begin
        w_gnt = 1'b1;
        if (r_we) begin
          w_mem_we     = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_state_next = RWAIT;
        end
      end
      RWAIT: begin
        if (r_lat_cnt == '0) begin
          w_rvalid     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Strobes are masked while rst is high so an aborted access never signals completion.
  assign p_gnt    = w_gnt    & (r_owner == OWN_P) & ~rst;
  assign d_gnt    = w_gnt    & (r_owner == OWN_D) & ~rst;
  assign p_rvalid = w_rvalid & (r_owner == OWN_P) & ~rst;
  assign d_rvalid = w_rvalid & (r_owner == OWN_D) & ~rst;
  assign mem_we   = w_mem_we & ~rst;

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = mem_rdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (read latency 1 and 3), a transaction-level model
// checked every cycle, and directed scenarios with literal expectations.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst      [2];
  logic       p_req    [2];
  logic       p_we     [2];
  logic [8:0] p_addr   [2];
  logic [8:0] p_wdata  [2];
  logic       p_gnt    [2];
  logic       p_rvalid [2];
  logic       d_req    [2];
  logic       d_we     [2];
  logic [8:0] d_addr   [2];
  logic [8:0] d_wdata  [2];
  logic       d_gnt    [2];
  logic       d_rvalid [2];
  logic [8:0] rdata    [2];
  logic [8:0] mem_addr [2];
  logic [8:0] mem_wdata[2];
  logic       mem_we   [2];
  logic [8:0] mem_rdata[2];
  logic       busy     [2];

  int checks   = 0;
  int failures = 0;

  mem_bus_arbiter #(.AW(9), .DW(9), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .p_req(p_req[0]), .p_we(p_we[0]), .p_addr(p_addr[0]), .p_wdata(p_wdata[0]),
    .p_gnt(p_gnt[0]), .p_rvalid(p_rvalid[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]),
    .rdata(rdata[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_we(mem_we[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_bus_arbiter #(.AW(9), .DW(9), .RD_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .p_req(p_req[1]), .p_we(p_we[1]), .p_addr(p_addr[1]), .p_wdata(p_wdata[1]),
    .p_gnt(p_gnt[1]), .p_rvalid(p_rvalid[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]),
    .rdata(rdata[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_we(mem_we[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  // Environment memories: synchronous write, read data RD_LAT cycles after the issue cycle.
  logic [8:0] bmem0 [512];
  logic [8:0] bmem1 [512];
  logic [8:0] rp0;
  logic [8:0] rp1 [3];

  always @(posedge clk) begin
    if (mem_we[0]) bmem0[mem_addr[0]] <= mem_wdata[0];
    if (mem_we[1]) bmem1[mem_addr[1]] <= mem_wdata[1];
    rp0    <= mem_addr[0];
    rp1[0] <= mem_addr[1];
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end

  assign mem_rdata[0] = bmem0[rp0];
  assign mem_rdata[1] = bmem1[rp1[2]];

  // Transaction model: an access occupies cycles k=0..len-1 after its sampling edge;
  // grant at k=0, read data at k=RD_LAT; writes last only the k=0 cycle.
  bit         m_active [2];
  int         m_k      [2];
  bit         m_owner  [2];
  bit         m_we     [2];
  bit         m_last   [2];
  logic [8:0] m_addr   [2];
  logic [8:0] m_wdata  [2];
  logic [8:0] mmem0    [512];
  logic [8:0] mmem1    [512];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit pick(input bit p, input bit d, input bit last);
    if (p && d) return !last;
    return d;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_active[i] <= 1'b0;
        m_last[i]   <= 1'b1;
        m_addr[i]   <= '0;
        m_wdata[i]  <= '0;
      end else if (m_active[i]) begin
        if (m_k[i] == 0 && m_we[i]) begin
          if (i == 0) mmem0[m_addr[i]] <= m_wdata[i];
          else        mmem1[m_addr[i]] <= m_wdata[i];
        end
        if ((m_we[i] && m_k[i] == 0) || (!m_we[i] && m_k[i] == lat_of(i)))
          m_active[i] <= 1'b0;
        else
          m_k[i] <= m_k[i] + 1;
      end else if (p_req[i] || d_req[i]) begin
        m_active[i] <= 1'b1;
        m_k[i]      <= 0;
        m_owner[i]  <= pick(p_req[i], d_req[i], m_last[i]);
        m_last[i]   <= pick(p_req[i], d_req[i], m_last[i]);
        m_we[i]     <= pick(p_req[i], d_req[i], m_last[i]) ? d_we[i]    : p_we[i];
        m_addr[i]   <= pick(p_req[i], d_req[i], m_last[i]) ? d_addr[i]  : p_addr[i];
        m_wdata[i]  <= pick(p_req[i], d_req[i], m_last[i]) ? d_wdata[i] : p_wdata[i];
      end
    end
  end

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit g, rv;
      logic [8:0] exp_rd;
      g      = !rst[i] && m_active[i] && m_k[i] == 0;
      rv     = !rst[i] && m_active[i] && !m_we[i] && m_k[i] == lat_of(i);
      exp_rd = (i == 0) ? mmem0[m_addr[i]] : mmem1[m_addr[i]];
      chk($sformatf("u%0d.p_gnt", i),     p_gnt[i],     g  && !m_owner[i]);
      chk($sformatf("u%0d.d_gnt", i),     d_gnt[i],     g  &&  m_owner[i]);
      chk($sformatf("u%0d.p_rvalid", i),  p_rvalid[i],  rv && !m_owner[i]);
      chk($sformatf("u%0d.d_rvalid", i),  d_rvalid[i],  rv &&  m_owner[i]);
      chk($sformatf("u%0d.mem_we", i),    mem_we[i],    g  &&  m_we[i]);
      chk($sformatf("u%0d.busy", i),      busy[i],      m_active[i]);
      chk($sformatf("u%0d.mem_addr", i),  mem_addr[i],  m_addr[i]);
      chk($sformatf("u%0d.mem_wdata", i), mem_wdata[i], m_wdata[i]);
      if (rv) chk($sformatf("u%0d.rdata", i), rdata[i], exp_rd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int i, output bit who, output bit ok);
    ok  = 1'b0;
    who = 1'b0;
    for (int n = 0; n < 8 && !ok; n++) begin
      cyc();
      if (p_gnt[i] || d_gnt[i]) begin
        ok  = 1'b1;
        who = d_gnt[i];
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_order [4];
    bit who, ok;
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
      d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
    end

    // Reset held for two cycles.
    for (int n = 0; n < 2; n++) begin
      cyc();
      chk("rst.busy", busy[0], 1'b0);
      chk("rst.mem_we", mem_we[0], 1'b0);
      chk("rst.mem_addr", mem_addr[0], 9'h000);
      chk("rst.gnt", p_gnt[0] | d_gnt[0], 1'b0);
      chk("rst.rvalid", p_rvalid[0] | d_rvalid[0], 1'b0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // P write only.
    p_req[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 9'h005; p_wdata[0] = 9'h1A7;
    cyc();
    chk("pwr.mem_addr", mem_addr[0], 9'h005);
    chk("pwr.mem_wdata", mem_wdata[0], 9'h1A7);
    chk("pwr.mem_we", mem_we[0], 1'b1);
    chk("pwr.p_gnt", p_gnt[0], 1'b1);
    chk("pwr.d_gnt", d_gnt[0], 1'b0);
    p_req[0] = 1'b0; p_we[0] = 1'b0;
    cyc();
    chk("pwr.idle", busy[0], 1'b0);

    // D preloads 0x0C3 at 0x10, then reads it back with RD_LAT=1.
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 9'h010; d_wdata[0] = 9'h0C3;
    cyc();
    chk("dpre.d_gnt", d_gnt[0], 1'b1);
    d_req[0] = 1'b0;
    cyc();
    d_req[0] = 1'b1; d_we[0] = 1'b0;
    cyc();
    chk("drd.d_gnt", d_gnt[0], 1'b1);
    chk("drd.mem_we", mem_we[0], 1'b0);
    d_req[0] = 1'b0;
    cyc();
    chk("drd.d_rvalid", d_rvalid[0], 1'b1);
    chk("drd.rdata", rdata[0], 9'h0C3);
    chk("drd.p_rvalid", p_rvalid[0], 1'b0);
    cyc();
    chk("drd.idle", busy[0], 1'b0);

    // Both masters held after reset: grants alternate starting with P.
    rst[0] = 1'b1;
    cyc();
    rst[0] = 1'b0;
    p_req[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 9'h020; p_wdata[0] = 9'h011;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 9'h021; d_wdata[0] = 9'h022;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(0, who, ok);
      chk($sformatf("rr.grant%0d_seen", g), ok, 1'b1);
      chk($sformatf("rr.grant%0d_owner", g), who, exp_order[g]);
    end
    p_req[0] = 1'b0; d_req[0] = 1'b0;
    cyc();
    cyc();

    // Reset during the RWAIT of a P read; the still-pending request is granted afterwards.
    p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 9'h005;
    cyc();
    chk("abort.p_gnt", p_gnt[0], 1'b1);
    cyc();
    rst[0] = 1'b1;
    #1;
    chk("abort.p_rvalid", p_rvalid[0], 1'b0);
    cyc();
    chk("abort.idle", busy[0], 1'b0);
    rst[0] = 1'b0;
    cyc();
    chk("abort.regrant", p_gnt[0], 1'b1);
    p_req[0] = 1'b0;
    cyc();
    chk("abort.p_rvalid2", p_rvalid[0], 1'b1);
    chk("abort.rdata", rdata[0], 9'h1A7);
    cyc();

    // RD_LAT=3 instance: preload, P read, D request raised during the wait.
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 9'h033; d_wdata[1] = 9'h155;
    cyc();
    chk("l3.pre_gnt", d_gnt[1], 1'b1);
    d_req[1] = 1'b0;
    cyc();
    p_req[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 9'h033;
    cyc();
    chk("l3.p_gnt", p_gnt[1], 1'b1);
    p_req[1] = 1'b0;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 9'h033;
    for (int n = 1; n <= 2; n++) begin
      cyc();
      chk($sformatf("l3.wait%0d_p_rvalid", n), p_rvalid[1], 1'b0);
      chk($sformatf("l3.wait%0d_d_gnt", n), d_gnt[1], 1'b0);
    end
    cyc();
    chk("l3.p_rvalid", p_rvalid[1], 1'b1);
    chk("l3.rdata", rdata[1], 9'h155);
    cyc();
    chk("l3.idle", busy[1], 1'b0);
    cyc();
    chk("l3.d_gnt", d_gnt[1], 1'b1);
    d_req[1] = 1'b0;
    cyc();
    cyc();
    chk("l3.d_rvalid_early", d_rvalid[1], 1'b0);
    cyc();
    chk("l3.d_rvalid", d_rvalid[1], 1'b1);
    chk("l3.d_rdata", rdata[1], 9'h155);
    chk("l3.p_rvalid_off", p_rvalid[1], 1'b0);
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
